// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// N-channel arbiter between sram-like master ports (fetch, data, walkers,
// refills, ...) and a single shared sram-like slave port. Each accepted
// request is tagged with its channel index on s_id; responses are routed
// back to the channel named by s_rid. Per channel the block tracks the
// number of outstanding requests (bounded by MAX_OUTST) and, after a
// cancel, the number of in-flight responses that must be swallowed.
//
// Parameters
//   NCH       number of master channels (1..16)
//   AW, DW    address / data width
//   IDW       slave ID width, 2**IDW >= NCH
//   MAX_OUTST outstanding request limit per channel (1..15)
//   RR        1 = round-robin, 0 = fixed priority (channel 0 highest)
//
// Ports
//   clk, resetn         clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata
//                       per-channel request fields, flattened, channel i in
//                       slice i of each bus
//   m_cancel            per-channel flush pulse
//   m_addr_ok           per-channel request accepted this cycle
//   m_data_ok           per-channel response delivered this cycle
//   m_rdata             slave read data, broadcast to all channels
//   m_busy              channel has outstanding requests
//   s_req .. s_id       request towards the slave, taken from the granted
//                       channel (all zero when nothing is granted)
//   s_addr_ok           slave accepted the request
//   s_data_ok/s_rid/s_rdata
//                       slave response and the channel it belongs to
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
   parameter int NCH       = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int IDW       = 4,
   parameter int MAX_OUTST = 4,
   parameter int RR        = 1
) (
   input  logic                clk,
   input  logic                resetn,
   // master side
   input  logic [NCH-1:0]      m_req,
   input  logic [NCH-1:0]      m_wr,
   input  logic [2*NCH-1:0]    m_size,
   input  logic [4*NCH-1:0]    m_wstrb,
   input  logic [AW*NCH-1:0]   m_addr,
   input  logic [DW*NCH-1:0]   m_wdata,
   input  logic [NCH-1:0]      m_cancel,
   output logic [NCH-1:0]      m_addr_ok,
   output logic [NCH-1:0]      m_data_ok,
   output logic [DW-1:0]       m_rdata,
   output logic [NCH-1:0]      m_busy,
   // slave side
   output logic                s_req,
   output logic                s_wr,
   output logic [1:0]          s_size,
   output logic [3:0]          s_wstrb,
   output logic [AW-1:0]       s_addr,
   output logic [DW-1:0]       s_wdata,
   output logic [IDW-1:0]      s_id,
   input  logic                s_addr_ok,
   input  logic                s_data_ok,
   input  logic [IDW-1:0]      s_rid,
   input  logic [DW-1:0]       s_rdata
);

   localparam int          PW      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [3:0]  CNT_MAX = 4'(MAX_OUTST);

   // per-channel tracking state
   logic [3:0]     outst     [NCH];
   logic [3:0]     disc      [NCH];
   logic [3:0]     outst_nxt [NCH];
   logic [3:0]     disc_nxt  [NCH];
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  ptr_nxt;

   // request path
   logic [NCH-1:0] eligible;
   logic [NCH-1:0] grant;
   logic [NCH-1:0] accept;
   logic [PW-1:0]  gnt_idx;
   logic           gnt_found;

   // response path
   logic [NCH-1:0] resp_vec;

   // --------------------------------------------------------------------------
   // Eligibility: a cancelling or full channel never competes.
   // --------------------------------------------------------------------------
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         eligible[i] = m_req[i] & ~m_cancel[i] & (outst[i] < CNT_MAX);
      end
   end

   // --------------------------------------------------------------------------
   // Grant: walk channels starting at ptr (round-robin) or at 0 (fixed
   // priority); the first eligible one wins. The search position is wrapped
   // by a conditional subtract instead of a modulo.
   // --------------------------------------------------------------------------
   always_comb begin
      int unsigned pos;
      grant     = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      pos       = 0;
      for (int unsigned off = 0; off < NCH; off++) begin
         if (RR != 0) begin
            pos = 32'(ptr) + off;
         end else begin
            pos = off;
         end
         if (pos >= NCH) begin
            pos = pos - NCH;
         end
         for (int unsigned i = 0; i < NCH; i++) begin
            if (!gnt_found && (i == pos) && eligible[i]) begin
               gnt_found = 1'b1;
               grant[i]  = 1'b1;
               gnt_idx   = PW'(i);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Slave request mux, driven from the one-hot grant; all zero when idle.
   // --------------------------------------------------------------------------
   always_comb begin
      s_wr    = 1'b0;
      s_size  = '0;
      s_wstrb = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_id    = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            s_wr    = m_wr[i];
            s_size  = m_size[2*i +: 2];
            s_wstrb = m_wstrb[4*i +: 4];
            s_addr  = m_addr[AW*i +: AW];
            s_wdata = m_wdata[DW*i +: DW];
            s_id    = IDW'(i);
         end
      end
   end

   assign s_req     = |eligible;
   assign accept    = grant & {NCH{s_addr_ok}};
   assign m_addr_ok = accept;

   // --------------------------------------------------------------------------
   // Response routing. An s_rid outside 0..NCH-1 matches no channel and is
   // therefore ignored. A response is swallowed while discards are pending
   // or while the channel is cancelling in the same cycle.
   // --------------------------------------------------------------------------
   always_comb begin
      resp_vec  = '0;
      m_data_ok = '0;
      m_busy    = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         resp_vec[i]  = s_data_ok & (s_rid == IDW'(i));
         m_data_ok[i] = resp_vec[i] & (disc[i] == 4'd0) & ~m_cancel[i];
         m_busy[i]    = (outst[i] != 4'd0);
      end
   end

   assign m_rdata = s_rdata;

   // --------------------------------------------------------------------------
   // Counter next state.
   // A cancel captures everything still in flight, except a response that
   // retires this very cycle (it is swallowed directly by the cancel).
   // --------------------------------------------------------------------------
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         outst_nxt[i] = outst[i];
         disc_nxt[i]  = disc[i];
         case ({accept[i], resp_vec[i]})
            2'b10:   outst_nxt[i] = outst[i] + 4'd1;
            2'b01:   outst_nxt[i] = outst[i] - 4'd1;
            default: outst_nxt[i] = outst[i];
         endcase
         if (m_cancel[i]) begin
            disc_nxt[i] = outst[i] - {3'b000, resp_vec[i]};
         end else if (resp_vec[i] && (disc[i] != 4'd0)) begin
            disc_nxt[i] = disc[i] - 4'd1;
         end
      end
   end

   // Priority pointer: moves just past the channel accepted this cycle.
   always_comb begin
      ptr_nxt = ptr;
      if ((RR != 0) && (NCH > 1) && s_addr_ok && gnt_found) begin
         if (gnt_idx == PW'(NCH - 1)) begin
            ptr_nxt = '0;
         end else begin
            ptr_nxt = gnt_idx + PW'(1);
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            outst[i] <= '0;
            disc[i]  <= '0;
         end
         ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            outst[i] <= outst_nxt[i];
            disc[i]  <= disc_nxt[i];
         end
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
//
// Three arbiter instances share one set of inputs:
//   0: round-robin, MAX_OUTST=4
//   1: fixed priority, MAX_OUTST=4
//   2: round-robin, MAX_OUTST=2
// Each phase targets one instance (sel). Stimulus pushes the expected
// accepts/responses into queues; a monitor pops and compares whenever the
// selected instance raises m_addr_ok or m_data_ok.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;

   localparam int NCH = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int IDW = 4;
   localparam int NI  = 3;

   localparam logic [AW-1:0] ADDR0  = 32'h1000_0010;
   localparam logic [AW-1:0] ADDR1  = 32'h2000_0040;
   localparam logic [DW-1:0] WDATA1 = 32'hcafe_0001;

   logic                clk = 1'b0;
   logic                resetn;
   logic [NCH-1:0]      m_req, m_wr, m_cancel;
   logic [2*NCH-1:0]    m_size;
   logic [4*NCH-1:0]    m_wstrb;
   logic [AW*NCH-1:0]   m_addr;
   logic [DW*NCH-1:0]   m_wdata;
   logic                s_addr_ok, s_data_ok;
   logic [IDW-1:0]      s_rid;
   logic [DW-1:0]       s_rdata;

   logic [NCH-1:0]      o_addr_ok [NI];
   logic [NCH-1:0]      o_data_ok [NI];
   logic [DW-1:0]       o_rdata   [NI];
   logic [NCH-1:0]      o_busy    [NI];
   logic                o_s_req   [NI];
   logic                o_s_wr    [NI];
   logic [1:0]          o_s_size  [NI];
   logic [3:0]          o_s_wstrb [NI];
   logic [AW-1:0]       o_s_addr  [NI];
   logic [DW-1:0]       o_s_wdata [NI];
   logic [IDW-1:0]      o_s_id    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sram_like_arbiter #(
         .NCH      (NCH),
         .AW       (AW),
         .DW       (DW),
         .IDW      (IDW),
         .MAX_OUTST((g == 2) ? 2 : 4),
         .RR       ((g == 1) ? 0 : 1)
      ) u_dut (
         .clk      (clk),
         .resetn   (resetn),
         .m_req    (m_req),
         .m_wr     (m_wr),
         .m_size   (m_size),
         .m_wstrb  (m_wstrb),
         .m_addr   (m_addr),
         .m_wdata  (m_wdata),
         .m_cancel (m_cancel),
         .m_addr_ok(o_addr_ok[g]),
         .m_data_ok(o_data_ok[g]),
         .m_rdata  (o_rdata[g]),
         .m_busy   (o_busy[g]),
         .s_req    (o_s_req[g]),
         .s_wr     (o_s_wr[g]),
         .s_size   (o_s_size[g]),
         .s_wstrb  (o_s_wstrb[g]),
         .s_addr   (o_s_addr[g]),
         .s_wdata  (o_s_wdata[g]),
         .s_id     (o_s_id[g]),
         .s_addr_ok(s_addr_ok),
         .s_data_ok(s_data_ok),
         .s_rid    (s_rid),
         .s_rdata  (s_rdata)
      );
   end

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      int            ch;
      logic [AW-1:0] addr;
      logic          wr;
      logic [3:0]    wstrb;
      logic [DW-1:0] wdata;
   } acc_t;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
   } dat_t;

   acc_t exp_acc[$];
   dat_t exp_dat[$];

   int n_chk  = 0;
   int n_fail = 0;
   int sel    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (inst %0d, t=%0t)", name, act, exp, sel, $time);
      end
   endtask

   task automatic push_acc(input int ch);
      acc_t e;
      e.ch    = ch;
      e.addr  = (ch == 1) ? ADDR1 : ADDR0;
      e.wr    = (ch == 1);
      e.wstrb = (ch == 1) ? 4'hf : 4'h0;
      e.wdata = (ch == 1) ? WDATA1 : '0;
      exp_acc.push_back(e);
   endtask

   task automatic push_dat(input int ch, input logic [DW-1:0] d);
      dat_t e;
      e.ch   = ch;
      e.data = d;
      exp_dat.push_back(e);
   endtask

   // Monitor: samples the selected instance on the falling edge.
   always @(negedge clk) begin
      if (resetn) begin
         for (int c = 0; c < NCH; c++) begin
            if (o_addr_ok[sel][c]) begin
               if (exp_acc.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL acc_unexpected: got accept on ch %0d, expected none (t=%0t)", c, $time);
               end else begin
                  acc_t e;
                  e = exp_acc.pop_front();
                  check("acc_ch",    64'(c),              64'(e.ch));
                  check("acc_id",    64'(o_s_id[sel]),    64'(e.ch));
                  check("acc_addr",  64'(o_s_addr[sel]),  64'(e.addr));
                  check("acc_wr",    64'(o_s_wr[sel]),    64'(e.wr));
                  check("acc_size",  64'(o_s_size[sel]),  64'(2));
                  check("acc_wstrb", 64'(o_s_wstrb[sel]), 64'(e.wstrb));
                  check("acc_wdata", 64'(o_s_wdata[sel]), 64'(e.wdata));
               end
            end
            if (o_data_ok[sel][c]) begin
               if (exp_dat.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL dat_unexpected: got data_ok on ch %0d, expected none (t=%0t)", c, $time);
               end else begin
                  dat_t e;
                  e = exp_dat.pop_front();
                  check("dat_ch",    64'(c),            64'(e.ch));
                  check("dat_rdata", 64'(o_rdata[sel]), 64'(e.data));
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic clear_inputs();
      m_req     = '0;
      m_cancel  = '0;
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
      s_rid     = '0;
      s_rdata   = '0;
   endtask

   // Start a new cycle just after the rising edge with per-cycle inputs idle.
   task automatic cyc();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic resp(input logic [IDW-1:0] rid, input logic [DW-1:0] d);
      s_data_ok = 1'b1;
      s_rid     = rid;
      s_rdata   = d;
   endtask

   function automatic logic any_out(input int g);
      return (|o_addr_ok[g]) | (|o_data_ok[g]) | (|o_rdata[g]) | (|o_busy[g]) |
             o_s_req[g] | o_s_wr[g] | (|o_s_size[g]) | (|o_s_wstrb[g]) |
             (|o_s_addr[g]) | (|o_s_wdata[g]) | (|o_s_id[g]);
   endfunction

   task automatic do_reset(input int s);
      cyc();
      resetn = 1'b0;
      sel    = s;
      @(negedge clk);
      for (int g = 0; g < NI; g++) check("reset_outputs", 64'(any_out(g)), 64'(0));
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic queues_empty(input string tag);
      check({tag, "_acc_q"}, 64'(exp_acc.size()), 64'(0));
      check({tag, "_dat_q"}, 64'(exp_dat.size()), 64'(0));
   endtask

   initial begin
      resetn  = 1'b0;
      clear_inputs();
      m_wr    = 2'b10;
      m_size  = 4'b10_10;
      m_wstrb = {4'hf, 4'h0};
      m_addr  = {ADDR1, ADDR0};
      m_wdata = {WDATA1, 32'h0};

      // ---- round-robin alternation, outst ends {2,2}
      do_reset(0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         m_req = 2'b11; s_addr_ok = 1'b1;
         push_acc(k % 2);
         @(negedge clk);
         check("rr_grant", 64'(o_addr_ok[0]), (k % 2) ? 64'h2 : 64'h1);
      end
      cyc(); resp(4'd0, 32'h0000_00a0); push_dat(0, 32'h0000_00a0);
      cyc(); resp(4'd1, 32'h0000_00a1); push_dat(1, 32'h0000_00a1);
      cyc(); resp(4'd0, 32'h0000_00a2); push_dat(0, 32'h0000_00a2);
      @(negedge clk);
      check("rr_busy_mid", 64'(o_busy[0]), 64'h3);
      cyc(); resp(4'd1, 32'h0000_00a3); push_dat(1, 32'h0000_00a3);
      cyc();
      @(negedge clk);
      check("rr_busy_end", 64'(o_busy[0]), 64'h0);
      queues_empty("rr");

      // ---- fixed priority: ch0 wins until full, then ch1
      do_reset(1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         m_req = 2'b11; s_addr_ok = 1'b1;
         push_acc(0);
         @(negedge clk);
         check("fp_grant0", 64'(o_addr_ok[1]), 64'h1);
      end
      cyc();
      m_req = 2'b11; s_addr_ok = 1'b1;
      push_acc(1);
      @(negedge clk);
      check("fp_full_ch1", 64'(o_addr_ok[1]), 64'h2);
      cyc();
      @(negedge clk);
      queues_empty("fp");

      // ---- full condition with MAX_OUTST=2
      do_reset(2);
      for (int k = 0; k < 2; k++) begin
         cyc(); m_req = 2'b01; s_addr_ok = 1'b1; push_acc(0);
      end
      cyc(); m_req = 2'b01; s_addr_ok = 1'b1;
      @(negedge clk);
      check("full_sreq", 64'(o_s_req[2]), 64'h0);
      check("full_aok",  64'(o_addr_ok[2]), 64'h0);
      cyc(); m_req = 2'b01; s_addr_ok = 1'b1;
      resp(4'd0, 32'h0000_00b0); push_dat(0, 32'h0000_00b0);
      @(negedge clk);
      check("full_sreq_resp", 64'(o_s_req[2]), 64'h0);
      cyc(); m_req = 2'b01; s_addr_ok = 1'b1; push_acc(0);
      @(negedge clk);
      check("full_sreq_next", 64'(o_s_req[2]), 64'h1);
      cyc(); resp(4'd0, 32'h0000_00b1); push_dat(0, 32'h0000_00b1);
      cyc(); resp(4'd0, 32'h0000_00b2); push_dat(0, 32'h0000_00b2);
      cyc();
      @(negedge clk);
      check("full_busy_end", 64'(o_busy[2]), 64'h0);
      queues_empty("full");

      // ---- cancel with a response in the cancel cycle
      do_reset(0);
      for (int k = 0; k < 3; k++) begin
         cyc(); m_req = 2'b01; s_addr_ok = 1'b1; push_acc(0);
      end
      cyc();
      m_req = 2'b01; s_addr_ok = 1'b1; m_cancel = 2'b01;
      resp(4'd0, 32'h0000_00c0);
      @(negedge clk);
      check("cancel_sreq", 64'(o_s_req[0]), 64'h0);
      check("cancel_swallow", 64'(o_data_ok[0]), 64'h0);
      cyc(); m_req = 2'b01; s_addr_ok = 1'b1; push_acc(0);
      for (int k = 0; k < 2; k++) begin
         cyc(); resp(4'd0, 32'h0000_00c1);
         @(negedge clk);
         check("cancel_disc", 64'(o_data_ok[0]), 64'h0);
      end
      cyc(); resp(4'd0, 32'h0000_00c4); push_dat(0, 32'h0000_00c4);
      @(negedge clk);
      check("cancel_after", 64'(o_data_ok[0]), 64'h1);
      cyc();
      @(negedge clk);
      check("cancel_busy_end", 64'(o_busy[0]), 64'h0);
      queues_empty("cancel");

      // ---- simultaneous accept+response on ch1, then out-of-range rid
      cyc(); m_req = 2'b10; s_addr_ok = 1'b1; push_acc(1);
      cyc(); m_req = 2'b10; s_addr_ok = 1'b1; push_acc(1);
      resp(4'd1, 32'h0000_00d0); push_dat(1, 32'h0000_00d0);
      cyc(); resp(4'd5, 32'h0000_00d5);
      @(negedge clk);
      check("rid5_dok",  64'(o_data_ok[0]), 64'h0);
      check("rid5_busy", 64'(o_busy[0]), 64'h2);
      cyc(); resp(4'd1, 32'h0000_00d1); push_dat(1, 32'h0000_00d1);
      cyc();
      @(negedge clk);
      check("simul_busy_end", 64'(o_busy[0]), 64'h0);
      queues_empty("simul");

      // ---- asynchronous reset mid-clock with outst={3,1}
      for (int k = 0; k < 3; k++) begin
         cyc(); m_req = 2'b01; s_addr_ok = 1'b1; push_acc(0);
      end
      cyc(); m_req = 2'b10; s_addr_ok = 1'b1; push_acc(1);
      cyc();
      @(negedge clk);
      check("pre_reset_busy", 64'(o_busy[0]), 64'h3);
      #1 resetn = 1'b0;
      #1;
      check("async_reset_busy", 64'(o_busy[0]), 64'h0);
      check("async_reset_out",  64'(any_out(0)), 64'h0);
      @(posedge clk);
      #1 resetn = 1'b1;
      cyc(); m_req = 2'b01; s_addr_ok = 1'b1; push_acc(0);
      cyc(); resp(4'd0, 32'h0000_00e0); push_dat(0, 32'h0000_00e0);
      cyc();
      @(negedge clk);
      check("post_reset_busy", 64'(o_busy[0]), 64'h0);
      queues_empty("reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter between the core's sram-like master ports (instruction fetch, data access, and future channels such as a TLB walker or cache refill) and one shared sram-like slave port feeding the AXI bridge. It generalises the current fixed inst/data pairing:

- Channel count, widths and arbitration mode are parameters.
- Each request is tagged with a channel ID, and responses are routed back by ID.
- Outstanding requests are tracked per channel with a depth limit.
- Per-channel cancel discards responses still in flight, covering the exception/ertn flush of a fetch stage.

## Interface
- NCH, 2: number of master channels (1..16).
- AW, 32: address width.
- DW, 32: data width.
- IDW, 4: slave ID width; 2^IDW >= NCH required.
- MAX_OUTST, 4: maximum outstanding requests per channel (1..15).
- RR, 1: 1 selects round-robin arbitration, 0 selects fixed priority (channel 0 highest).
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- m_req  in  NCH  per-channel request.
- m_wr  in  NCH  per-channel write flag.
- m_size  in  2*NCH  per-channel size; channel i uses bits [2i+1:2i].
- m_wstrb  in  4*NCH  per-channel byte strobe.
- m_addr  in  AW*NCH  per-channel address.
- m_wdata  in  DW*NCH  per-channel write data.
- m_cancel  in  NCH  per-channel flush pulse.
- m_addr_ok  out  NCH  per-channel request accepted.
- m_data_ok  out  NCH  per-channel response delivered.
- m_rdata  out  DW  s_rdata broadcast to all channels.
- m_busy  out  NCH  channel has outstanding requests (outst[i] != 0).
- s_req, s_wr  out  1, 1  slave request and write flag.
- s_size  out  2  slave size.
- s_wstrb  out  4  slave byte strobe.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_id  out  IDW  granted channel index.
- s_addr_ok  in  1  slave request accepted.
- s_data_ok  in  1  slave response valid.
- s_rid  in  IDW  response channel ID.
- s_rdata  in  DW  response data.

## Operation
- Per channel i, two registers, both 4 bits wide:
  - outst[i]: outstanding request count.
  - disc[i]: count of responses still to be discarded.
- One rotating priority pointer ptr, log2(NCH) bits.
- Request path:
  - eligible[i] = m_req[i] & ~m_cancel[i] & (outst[i] < MAX_OUTST).
  - Grant is combinational and one-hot over eligible channels.
    - RR=1: search starts at ptr.
    - RR=0: lowest index wins.
  - s_req = |eligible.
  - s_wr, s_size, s_wstrb, s_addr, s_wdata and s_id are taken from the granted channel.
  - With no grant, all s_* outputs are 0.
  - m_addr_ok[i] = grant[i] & s_addr_ok.
  - A non-granted request holds its fields stable until accepted (master obligation).
- Accept on grant[i] & s_addr_ok:
  - outst[i] increments.
  - If RR=1, ptr <= (i+1) mod NCH.
- Response on s_data_ok with s_rid == i < NCH:
  - outst[i] decrements.
  - If disc[i] != 0 or m_cancel[i], the response is swallowed: m_data_ok[i] = 0, and disc[i] decrements if it was nonzero.
  - Otherwise m_data_ok[i] = 1.
  - An s_rid >= NCH is ignored: no state change, no m_data_ok.
- Accept and response for the same channel in the same cycle: outst[i] is unchanged.
- Cancel:
  - m_cancel[i] sets disc[i] <= outst[i] - (response for i this cycle).
  - Every response still in flight for i, including one arriving in the cancel cycle, is swallowed.
  - A request from i in the cancel cycle is not granted.
  - Repeated cancel re-evaluates the same formula.
  - Other channels are unaffected.
- Responses within one channel are delivered in slave order; the slave must keep per-ID order.

## Timing
- Reset (resetn low, asynchronous): outst=0, disc=0, ptr=0.
  - With all inputs low, every output is 0.
  - Reset mid-transaction drops all tracking; the slave must also be reset.
- Request path s_req/s_* and m_addr_ok is zero-latency combinational from m_req and s_addr_ok.
  - No combinational path exists from s_data_ok into s_req.
- Response path m_data_ok is zero-latency combinational from s_data_ok, s_rid, m_cancel and disc.
- Counter and pointer updates are visible the cycle after the handshake.
- Full condition: a channel at outst == MAX_OUTST is ineligible.
  - A response that cycle makes it eligible only next cycle.
- Wrap-around: ptr wraps NCH-1 -> 0. With NCH=1, ptr is constant 0.

## Test plan
- NCH=2, RR=1: both m_req held high, s_addr_ok=1 for 4 cycles -> grants 0,1,0,1; s_id = 0,1,0,1; outst = {2,2}.
- RR=0, same stimulus -> channel 0 granted all 4 cycles; channel 1 sees m_addr_ok=0 throughout.
- MAX_OUTST=2, channel 0 only, s_addr_ok=1, no responses -> exactly 2 accepts, then s_req=0. Then one s_data_ok with rid=0 -> m_data_ok[0]=1, and s_req=1 on the following cycle.
- Channel 0 with outst=3, m_cancel[0] pulsed together with an s_data_ok rid=0 -> that response swallowed, disc[0]=2. Next two rid=0 responses give m_data_ok[0]=0. Fourth request, accepted after the cancel, then returns m_data_ok[0]=1.
- Simultaneous accept and response on channel 1 -> outst[1] unchanged. s_rid=5 with NCH=2 -> no m_data_ok, no counter change.
- resetn dropped asynchronously mid-clock with outst={3,1} -> all outputs 0 before the next edge; counters are 0 after release.
